alu_request_arbiter: RTL and testbench

Shares one combinational 32-bit ALU between two requesters, for example the integer issue path (port 0) and the address-generation path (port 1). Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin and latches the winning operands. It drives the shared ALU and holds it for extra cycles on multiply. It registers the result and returns it to the granted requester. Only one operation is in flight at a time.

---
 rtl/alu_request_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// ============================================================================
//  Module   : alu_request_arbiter
//  Purpose  : Round-robin sharing of one combinational 32-bit ALU between two
//             valid/ready requesters, with a multi-cycle hold for multiply.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_request_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        Req0Valid,
  output logic        Req0Ready,
  input  logic [31:0] Req0A,
  input  logic [31:0] Req0B,
  input  logic [3:0]  Req0Op,

  input  logic        Req1Valid,
  output logic        Req1Ready,
  input  logic [31:0] Req1A,
  input  logic [31:0] Req1B,
  input  logic [3:0]  Req1Op,

  output logic        Rsp0Valid,
  input  logic        Rsp0Ready,
  output logic        Rsp1Valid,
  input  logic        Rsp1Ready,
  output logic [31:0] RspData,
  output logic        RspErr,

  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [3:0]  AluOp,
  input  logic [31:0] AluRes
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  localparam logic [3:0] c_OP_MUL   = 4'b1110;
  localparam logic [3:0] c_MUL_LAST = 4'(MUL_CYCLES - 1);

  logic [1:0]  state_q,    state_d;
  logic        ptr_q,      ptr_d;      // 1: requester 1 wins a tie
  logic        owner_q,    owner_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [31:0] alu_a_q,    alu_a_d;
  logic [31:0] alu_b_q,    alu_b_d;
  logic [3:0]  alu_op_q,   alu_op_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q,  rsp_err_d;

  logic        grant0;
  logic        grant1;
  logic        accept0;
  logic        accept1;
  logic [3:0]  win_op;
  logic        op_legal;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1110: is_legal = 1'b1;
      default:                                    is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    grant0 = Req0Valid & (~Req1Valid | ~ptr_q);
    grant1 = Req1Valid & (~Req0Valid |  ptr_q);
  end

  // Ready is masked while reset is asserted so nothing is handed over that
  // the reset edge would then discard.
  assign Req0Ready = rst_n & (state_q == c_IDLE) & grant0;
  assign Req1Ready = rst_n & (state_q == c_IDLE) & grant1;

  assign accept0 = Req0Valid & Req0Ready;
  assign accept1 = Req1Valid & Req1Ready;
  assign win_op  = accept1 ? Req1Op : Req0Op;
  assign op_legal = is_legal(alu_op_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      c_IDLE: begin
        if (accept0 | accept1) begin
          alu_a_d  = accept1 ? Req1A : Req0A;
          alu_b_d  = accept1 ? Req1B : Req0B;
          alu_op_d = win_op;
          owner_d  = accept1;
          ptr_d    = ~accept1;
          cnt_d    = (win_op == c_OP_MUL) ? c_MUL_LAST : 4'd0;
          state_d  = c_EXEC;
        end
      end

      c_EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = op_legal ? AluRes : 32'd0;
          rsp_err_d  = ~op_legal;
          state_d    = c_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      c_RESP: begin
        if (owner_q ? Rsp1Ready : Rsp0Ready) begin
          state_d = c_IDLE;
        end
      end

      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= c_IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= 4'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_op_q   <= 4'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign Rsp0Valid = (state_q == c_RESP) & ~owner_q;
  assign Rsp1Valid = (state_q == c_RESP) &  owner_q;
  assign RspData   = rsp_data_q;
  assign RspErr    = rsp_err_q;
  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign AluOp     = alu_op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_request_arbiter.sv
// ============================================================================
//  Module   : tb_alu_request_arbiter
//  Purpose  : Directed, scoreboard-checked bench for alu_request_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_request_arbiter;

  localparam int unsigned MUL_CYCLES = 2;
  localparam logic [3:0] c_ADD = 4'b0000, c_SUB = 4'b1000, c_SLT = 4'b0010;
  localparam logic [3:0] c_XOR = 4'b0100, c_SRA = 4'b1101, c_OR  = 4'b0110;
  localparam logic [3:0] c_MUL = 4'b1110, c_BAD = 4'b1111;

  logic        clk;
  logic        rst_n;
  logic        Req0Valid, Req0Ready, Req1Valid, Req1Ready;
  logic [31:0] Req0A, Req0B, Req1A, Req1B;
  logic [3:0]  Req0Op, Req1Op;
  logic        Rsp0Valid, Rsp0Ready, Rsp1Valid, Rsp1Ready;
  logic [31:0] RspData;
  logic        RspErr;
  logic [31:0] AluA, AluB, AluRes;
  logic [3:0]  AluOp;

  alu_request_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
    .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready),
    .RspData(RspData), .RspErr(RspErr),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluRes(AluRes)
  );

  // Reference ALU; undefined codes return a non-zero pattern so zeroing is visible.
  always_comb begin
    case (AluOp)
      4'b0000: AluRes = AluA + AluB;
      4'b1000: AluRes = AluA - AluB;
      4'b0001: AluRes = AluA << AluB[4:0];
      4'b0010: AluRes = {31'd0, $signed(AluA) < $signed(AluB)};
      4'b0011: AluRes = {31'd0, AluA < AluB};
      4'b0100: AluRes = AluA ^ AluB;
      4'b0101: AluRes = AluA >> AluB[4:0];
      4'b1101: AluRes = 32'($signed(AluA) >>> AluB[4:0]);
      4'b0110: AluRes = AluA | AluB;
      4'b0111: AluRes = AluA & AluB;
      4'b1110: AluRes = AluA * AluB;
      default: AluRes = 32'hDEAD_BEEF;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  bit          grants[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_data[2];
  bit          exp_err[2];
  int          exp_lat[2];
  bit          prev_rsp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, want);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // Accepts push expectations; responses are compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    check("ready_exclusive", 32'(Req0Ready & Req1Ready), 32'd0);
    if (Req0Valid && Req0Ready) begin
      sb.push_back('{1'b0, exp_data[0], exp_err[0], cyc, exp_lat[0]});
      grants.push_back(1'b0);
    end
    if (Req1Valid && Req1Ready) begin
      sb.push_back('{1'b1, exp_data[1], exp_err[1], cyc, exp_lat[1]});
      grants.push_back(1'b1);
    end
    if (Rsp0Valid || Rsp1Valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_rsp: observed=valid expected=none");
      end else begin
        e = sb[0];
        check("rsp_owner", 32'({Rsp1Valid, Rsp0Valid}), e.port ? 32'd2 : 32'd1);
        check("rsp_data", RspData, e.data);
        check("rsp_err", 32'(RspErr), 32'(e.err));
        if (!prev_rsp) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        if ((Rsp0Valid && Rsp0Ready) || (Rsp1Valid && Rsp1Ready)) void'(sb.pop_front());
      end
    end
    prev_rsp = Rsp0Valid | Rsp1Valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] ed, input bit ee);
    exp_data[port] = ed;
    exp_err[port]  = ee;
    exp_lat[port]  = (op == c_MUL) ? int'(MUL_CYCLES) + 1 : 2;
    if (port) begin Req1A = a; Req1B = b; Req1Op = op; end
    else      begin Req0A = a; Req0B = b; Req0Op = op; end
  endtask

  task automatic wait_ready(input bit port);
    int n = 0;
    #1;
    while (!(port ? Req1Ready : Req0Ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail_now("ready_wait");
  endtask

  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] ed, input bit ee);
    set_req(port, a, b, op, ed, ee);
    if (port) Req1Valid = 1'b1; else Req0Valid = 1'b1;
    wait_ready(port);
    tick();
    if (port) Req1Valid = 1'b0; else Req0Valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() != 0) fail_now("drain");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    sb.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    Req0A = '0; Req0B = '0; Req0Op = '0;
    Req1A = '0; Req1B = '0; Req1Op = '0;
    Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
    exp_data[0] = '0; exp_data[1] = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    exp_lat[0] = 2; exp_lat[1] = 2;
    repeat (3) tick();

    // Reset values, with a valid present to confirm nothing is accepted.
    Req0Valid = 1'b1;
    #1;
    check("rst_req0_ready", 32'(Req0Ready), 32'd0);
    check("rst_rsp_valid", 32'({Rsp1Valid, Rsp0Valid}), 32'd0);
    check("rst_rsp_data", RspData, 32'd0);
    check("rst_rsp_err", 32'(RspErr), 32'd0);
    check("rst_alu_a", AluA, 32'd0);
    check("rst_alu_b", AluB, 32'd0);
    check("rst_alu_op", 32'(AluOp), 32'd0);
    Req0Valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: ADD wraps to zero
    set_req(0, 32'hFFFF_FFFF, 32'd1, c_ADD, 32'd0, 1'b0);
    Req0Valid = 1'b1;
    #1;
    check("t1_req0_ready", 32'(Req0Ready), 32'd1);
    tick();
    Req0Valid = 1'b0;
    check("t1_alu_a", AluA, 32'hFFFF_FFFF);
    check("t1_alu_b", AluB, 32'd1);
    check("t1_alu_op", 32'(AluOp), 32'(c_ADD));
    drain();

    // 2: both requesters always valid, fresh out of reset
    do_reset();
    grants.delete();
    set_req(0, 32'd5, 32'd7, c_SUB, 32'hFFFF_FFFE, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 32'd1, c_SLT, 32'd1, 1'b0);
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    begin
      int n = 0;
      while (grants.size() < 4 && n < 40) begin
        tick();
        n++;
      end
    end
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    if (grants.size() < 4) fail_now("t2_grants");
    else begin
      for (int i = 0; i < 4; i++) check("t2_grant_order", 32'(grants[i]), 32'(i % 2));
    end
    drain();

    // 3: MUL holds the ALU for MUL_CYCLES
    set_req(1, 32'h0001_0000, 32'h0001_0000, c_MUL, 32'd0, 1'b0);
    Req1Valid = 1'b1;
    wait_ready(1);
    tick();
    Req1Valid = 1'b0;
    check("t3_op_exec1", 32'(AluOp), 32'(c_MUL));
    check("t3_rsp1_exec1", 32'(Rsp1Valid), 32'd0);
    tick();
    check("t3_op_exec2", 32'(AluOp), 32'(c_MUL));
    check("t3_rsp1_exec2", 32'(Rsp1Valid), 32'd0);
    tick();
    check("t3_rsp1_valid", 32'(Rsp1Valid), 32'd1);
    drain();

    // 4: SRA with response backpressure; Req1 waits
    Rsp0Ready = 1'b0;
    set_req(0, 32'h8000_0000, 32'd4, c_SRA, 32'hF800_0000, 1'b0);
    Req0Valid = 1'b1;
    wait_ready(0);
    tick();
    Req0Valid = 1'b0;
    set_req(1, 32'hF0F0_F0F0, 32'hFF00_FF00, c_XOR, 32'h0FF0_0FF0, 1'b0);
    Req1Valid = 1'b1;
    #1;
    check("t4_req1_exec", 32'(Req1Ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_rsp0_held", 32'(Rsp0Valid), 32'd1);
      check("t4_req1_stall", 32'(Req1Ready), 32'd0);
      tick();
    end
    Rsp0Ready = 1'b1;
    tick();
    check("t4_req1_grant", 32'(Req1Ready), 32'd1);
    tick();
    Req1Valid = 1'b0;
    drain();

    // 5: illegal op, then a legal one
    issue(0, 32'd5, 32'd3, c_BAD, 32'd0, 1'b1);
    drain();
    issue(0, 32'h0000_00F0, 32'h0000_0F00, c_OR, 32'h0000_0FF0, 1'b0);
    drain();

    // 6: reset during MUL execution from requester 0
    set_req(0, 32'd3, 32'd7, c_MUL, 32'd21, 1'b0);
    Req0Valid = 1'b1;
    wait_ready(0);
    tick();
    Req0Valid = 1'b0;
    check("t6_exec_op", 32'(AluOp), 32'(c_MUL));
    rst_n = 1'b0;
    set_req(1, 32'h1234_5678, 32'hFFFF_0000, c_XOR, 32'hEDCB_5678, 1'b0);
    Req1Valid = 1'b1;
    tick();
    sb.delete();
    check("t6_rst_req1_ready", 32'(Req1Ready), 32'd0);
    check("t6_rst_rsp_valid", 32'({Rsp1Valid, Rsp0Valid}), 32'd0);
    check("t6_rst_rsp_data", RspData, 32'd0);
    check("t6_rst_rsp_err", 32'(RspErr), 32'd0);
    check("t6_rst_alu_a", AluA, 32'd0);
    check("t6_rst_alu_op", 32'(AluOp), 32'd0);
    rst_n = 1'b1;
    set_req(0, 32'd2, 32'd3, c_ADD, 32'd5, 1'b0);
    Req0Valid = 1'b1;
    #1;
    check("t6_ptr_req0", 32'(Req0Ready), 32'd1);
    check("t6_ptr_req1", 32'(Req1Ready), 32'd0);
    tick();
    Req0Valid = 1'b0;
    wait_ready(1);
    tick();
    Req1Valid = 1'b0;
    drain();

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
